// File: rtl/except_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// except_pkg : shared types and constants for the commit-side exception/ERTN
//              controller.                                      Rev 1.0
// ----------------------------------------------------------------------------
package except_pkg;

    localparam logic [5:0]  ECODE_INT  = 6'h00;
    localparam logic [5:0]  ECODE_ADEF = 6'h08;
    localparam logic [5:0]  ECODE_ALE  = 6'h09;
    localparam logic [5:0]  ECODE_SYS  = 6'h0B;
    localparam logic [5:0]  ECODE_BRK  = 6'h0C;
    localparam logic [5:0]  ECODE_INE  = 6'h0D;

    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    typedef enum logic {
        EV_EXC  = 1'b0,
        EV_ERTN = 1'b1
    } ev_kind_e;

    typedef struct packed {
        logic        valid;
        ev_kind_e    kind;
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] era;
        logic        badv_we;
        logic [31:0] badv;
    } ev_sel_t;

    // Only address-class faults report a bad virtual address.
    function automatic ev_sel_t make_exc(input logic [31:0] pc,
                                         input logic [5:0]  ecode,
                                         input logic [8:0]  esub,
                                         input logic [31:0] badaddr);
        ev_sel_t e;
        e          = '0;
        e.valid    = 1'b1;
        e.kind     = EV_EXC;
        e.ecode    = ecode;
        e.esubcode = esub;
        e.era      = pc;
        e.badv_we  = (ecode == ECODE_ADEF) || (ecode == ECODE_ALE);
        e.badv     = (ecode == ECODE_ADEF) ? pc :
                     ((ecode == ECODE_ALE) ? badaddr : 32'h0);
        return e;
    endfunction

    function automatic ev_sel_t make_ertn();
        ev_sel_t e;
        e       = '0;
        e.valid = 1'b1;
        e.kind  = EV_ERTN;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/except_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// except_ctrl_if : commit-stage / CSR / front-end signals of except_ctrl.
//                                                               Rev 1.0
// ----------------------------------------------------------------------------
interface except_ctrl_if;
    logic [1:0]  commit_valid;
    logic [31:0] commit_pc0,       commit_pc1;
    logic [1:0]  commit_except;
    logic [5:0]  commit_ecode0,    commit_ecode1;
    logic [8:0]  commit_esubcode0, commit_esubcode1;
    logic [31:0] commit_badaddr0,  commit_badaddr1;
    logic [1:0]  commit_ertn;
    logic        intr_pending;
    logic        csrwr_crmd_en;
    logic [31:0] csrwr_crmd_data;
    logic [31:0] PRMD, ERA_in, EENTRY;
    logic        backend_empty, redirect_ready;

    logic        except_en;
    logic [2:0]  CRMD_3;
    logic [31:0] CRMD;
    logic        commit_stall, flush;
    logic        era_we, estat_we, badv_we;
    logic [31:0] era_data, badv_data;
    logic [5:0]  estat_ecode;
    logic [8:0]  estat_esubcode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output commit_valid, commit_pc0, commit_pc1, commit_except,
               commit_ecode0, commit_ecode1, commit_esubcode0, commit_esubcode1,
               commit_badaddr0, commit_badaddr1, commit_ertn, intr_pending,
               csrwr_crmd_en, csrwr_crmd_data, PRMD, ERA_in, EENTRY,
               backend_empty, redirect_ready,
        input  except_en, CRMD_3, CRMD, commit_stall, flush, era_we, estat_we,
               badv_we, era_data, badv_data, estat_ecode, estat_esubcode,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  commit_valid, commit_pc0, commit_pc1, commit_except,
               commit_ecode0, commit_ecode1, commit_esubcode0, commit_esubcode1,
               commit_badaddr0, commit_badaddr1, commit_ertn, intr_pending,
               csrwr_crmd_en, csrwr_crmd_data, PRMD, ERA_in, EENTRY,
               backend_empty, redirect_ready,
        output except_en, CRMD_3, CRMD, commit_stall, flush, era_we, estat_we,
               badv_we, era_data, badv_data, estat_ecode, estat_esubcode,
               redirect_valid, redirect_pc
    );
endinterface
`default_nettype wire

// File: rtl/except_ctrl_sel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// except_sel : combinational priority pick of the oldest interrupt, exception
//              or ERTN among the two committing slots.          Rev 1.0
// ----------------------------------------------------------------------------
module except_sel
    import except_pkg::*;
(
    input  wire logic [1:0]  commit_valid_i,
    input  wire logic [31:0] commit_pc0_i,
    input  wire logic [31:0] commit_pc1_i,
    input  wire logic [1:0]  commit_except_i,
    input  wire logic [5:0]  commit_ecode0_i,
    input  wire logic [5:0]  commit_ecode1_i,
    input  wire logic [8:0]  commit_esubcode0_i,
    input  wire logic [8:0]  commit_esubcode1_i,
    input  wire logic [31:0] commit_badaddr0_i,
    input  wire logic [31:0] commit_badaddr1_i,
    input  wire logic [1:0]  commit_ertn_i,
    input  wire logic        intr_pending_i,
    input  wire logic        ie_i,
    output ev_sel_t          sel_o
);

    always_comb begin
        sel_o = '0;
        if (intr_pending_i && ie_i && commit_valid_i[0]) begin
            sel_o = make_exc(commit_pc0_i, ECODE_INT, 9'h0, 32'h0);
        end else if (commit_valid_i[0] && commit_except_i[0]) begin
            sel_o = make_exc(commit_pc0_i, commit_ecode0_i,
                             commit_esubcode0_i, commit_badaddr0_i);
        end else if (commit_valid_i[0] && commit_ertn_i[0]) begin
            sel_o = make_ertn();
        end else if (commit_valid_i[1] && commit_except_i[1]) begin
            sel_o = make_exc(commit_pc1_i, commit_ecode1_i,
                             commit_esubcode1_i, commit_badaddr1_i);
        end else if (commit_valid_i[1] && commit_ertn_i[1]) begin
            sel_o = make_ertn();
        end
    end

endmodule
`default_nettype wire

// File: rtl/except_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// except_ctrl : owns CRMD, raises exception/ERTN, then flush, drain, redirect.
//                                                               Rev 1.0
// ----------------------------------------------------------------------------
module except_ctrl
    import except_pkg::*;
(
    input  wire logic    clk,
    input  wire logic    rst_n,
    except_ctrl_if.slave bus
);

    ev_sel_t     w_sel;
    state_e      state_q, state_d;
    ev_kind_e    kind_q, kind_d;
    logic [8:0]  crmd_q, crmd_d;
    logic        except_en_q, except_en_d, flush_q, flush_d;
    logic        era_we_q, era_we_d, estat_we_q, estat_we_d, badv_we_q, badv_we_d;
    logic [31:0] era_data_q, era_data_d, badv_data_q, badv_data_d;
    logic [5:0]  ecode_q, ecode_d;
    logic [8:0]  esub_q, esub_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rpc_q, rpc_d;
    logic        unused_ok;

    except_sel u_sel (
        .commit_valid_i     (bus.commit_valid),
        .commit_pc0_i       (bus.commit_pc0),
        .commit_pc1_i       (bus.commit_pc1),
        .commit_except_i    (bus.commit_except),
        .commit_ecode0_i    (bus.commit_ecode0),
        .commit_ecode1_i    (bus.commit_ecode1),
        .commit_esubcode0_i (bus.commit_esubcode0),
        .commit_esubcode1_i (bus.commit_esubcode1),
        .commit_badaddr0_i  (bus.commit_badaddr0),
        .commit_badaddr1_i  (bus.commit_badaddr1),
        .commit_ertn_i      (bus.commit_ertn),
        .intr_pending_i     (bus.intr_pending),
        .ie_i               (crmd_q[2]),
        .sel_o              (w_sel)
    );

    always_comb begin
        state_d     = state_q;
        kind_d      = kind_q;
        crmd_d      = crmd_q;
        era_data_d  = era_data_q;
        badv_data_d = badv_data_q;
        ecode_d     = ecode_q;
        esub_d      = esub_q;
        rpc_d       = rpc_q;
        except_en_d = 1'b0;
        flush_d     = 1'b0;
        era_we_d    = 1'b0;
        estat_we_d  = 1'b0;
        badv_we_d   = 1'b0;
        rvalid_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_sel.valid) begin
                    state_d = ST_FLUSH;
                    kind_d  = w_sel.kind;
                    flush_d = 1'b1;
                    if (w_sel.kind == EV_EXC) begin
                        except_en_d = 1'b1;
                        era_we_d    = 1'b1;
                        estat_we_d  = 1'b1;
                        badv_we_d   = w_sel.badv_we;
                        era_data_d  = w_sel.era;
                        badv_data_d = w_sel.badv;
                        ecode_d     = w_sel.ecode;
                        esub_d      = w_sel.esubcode;
                    end
                end else if (bus.csrwr_crmd_en) begin
                    crmd_d = bus.csrwr_crmd_data[8:0];
                end
            end
            ST_FLUSH: begin
                // PRMD samples CRMD_3 on this same edge, so it sees the old mode.
                state_d     = ST_DRAIN;
                crmd_d[2:0] = (kind_q == EV_EXC) ? 3'b000 : bus.PRMD[2:0];
            end
            ST_DRAIN: begin
                if (bus.backend_empty) begin
                    state_d  = ST_REDIRECT;
                    rvalid_d = 1'b1;
                    rpc_d    = (kind_q == EV_EXC) ? bus.EENTRY : bus.ERA_in;
                end
            end
            ST_REDIRECT: begin
                if (bus.redirect_ready) state_d = ST_IDLE;
                else                    rvalid_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            kind_q      <= EV_EXC;
            crmd_q      <= CRMD_RESET[8:0];
            except_en_q <= 1'b0;
            flush_q     <= 1'b0;
            era_we_q    <= 1'b0;
            estat_we_q  <= 1'b0;
            badv_we_q   <= 1'b0;
            era_data_q  <= 32'h0;
            badv_data_q <= 32'h0;
            ecode_q     <= 6'h0;
            esub_q      <= 9'h0;
            rvalid_q    <= 1'b0;
            rpc_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            kind_q      <= kind_d;
            crmd_q      <= crmd_d;
            except_en_q <= except_en_d;
            flush_q     <= flush_d;
            era_we_q    <= era_we_d;
            estat_we_q  <= estat_we_d;
            badv_we_q   <= badv_we_d;
            era_data_q  <= era_data_d;
            badv_data_q <= badv_data_d;
            ecode_q     <= ecode_d;
            esub_q      <= esub_d;
            rvalid_q    <= rvalid_d;
            rpc_q       <= rpc_d;
        end
    end

    assign bus.except_en      = except_en_q;
    assign bus.CRMD           = {23'h0, crmd_q};
    assign bus.CRMD_3         = crmd_q[2:0];
    assign bus.commit_stall   = (state_q != ST_IDLE);
    assign bus.flush          = flush_q;
    assign bus.era_we         = era_we_q;
    assign bus.estat_we       = estat_we_q;
    assign bus.badv_we        = badv_we_q;
    assign bus.era_data       = era_data_q;
    assign bus.badv_data      = badv_data_q;
    assign bus.estat_ecode    = ecode_q;
    assign bus.estat_esubcode = esub_q;
    assign bus.redirect_valid = rvalid_q;
    assign bus.redirect_pc    = rpc_q;

    assign unused_ok = ^{bus.PRMD[31:3], bus.csrwr_crmd_data[31:9]};

endmodule
`default_nettype wire
